// File: rtl/cmd_frame_router.sv
// Frames opcode+payload host commands, delivers each payload to one of NUM_CHANNELS sinks and returns one status byte.
// Last byte -> out_m_valid next cycle; sink/rsp readies stall the FSM with valid/data held; stalled frames time out.
module cmd_frame_router #(
  parameter int unsigned NUM_CHANNELS                     = 4,
  parameter logic [7:0]  OPCODE_BASE                      = 8'hA0,
  parameter int unsigned MAX_PAYLOAD_BYTES                = 64,
  parameter int unsigned CH_PAYLOAD_BYTES [NUM_CHANNELS]  = '{default: 2},
  parameter int unsigned TIMEOUT_CYCLES                   = 4096,
  parameter int unsigned RESET_PULSE                      = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   cmd_s_valid,
  output logic                                   cmd_s_ready,
  input  logic [7:0]                             cmd_s_data,
  output logic                                   rsp_m_valid,
  input  logic                                   rsp_m_ready,
  output logic [7:0]                             rsp_m_data,
  output logic [NUM_CHANNELS-1:0]                out_m_valid,
  input  logic [NUM_CHANNELS-1:0]                out_m_ready,
  output logic [8*MAX_PAYLOAD_BYTES-1:0]         out_m_data,
  output logic [$clog2(MAX_PAYLOAD_BYTES+1)-1:0] out_m_len,
  output logic                                   cmd_reset,
  output logic [15:0]                            err_count
);

  localparam int unsigned LEN_W   = $clog2(MAX_PAYLOAD_BYTES + 1);
  localparam int unsigned CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PULSE_W = $clog2(RESET_PULSE + 1);
  localparam int unsigned BASE_I  = 32'(OPCODE_BASE);
  localparam int unsigned LAST_I  = BASE_I + NUM_CHANNELS - 1;

  localparam logic [7:0] RST_OP = 8'h55;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;
  localparam logic [7:0] TMO    = 8'h18;

  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_LEN = PULSE_W'(RESET_PULSE);

  if (NUM_CHANNELS < 1 || LAST_I > 255 || (BASE_I <= 32'h55 && LAST_I >= 32'h55)) begin : g_bad_opcode_range
    $error("cmd_frame_router: opcode range invalid or overlaps the reset opcode");
  end
  if (TIMEOUT_CYCLES < 2 || RESET_PULSE < 1) begin : g_bad_timing
    $error("cmd_frame_router: TIMEOUT_CYCLES must be >= 2 and RESET_PULSE >= 1");
  end
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_len_chk
    if (CH_PAYLOAD_BYTES[c] < 1 || CH_PAYLOAD_BYTES[c] > MAX_PAYLOAD_BYTES) begin : g_bad_len
      $error("cmd_frame_router: channel payload length out of range");
    end
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_DELIVER,
    S_RESET_CONFIRM,
    S_RESP
  } state_e;

  state_e                       state_q;
  logic [CH_W-1:0]              ch_q;
  logic [LEN_W-1:0]             bytes_left_q;
  logic [LEN_W-1:0]             len_q;
  logic [8*MAX_PAYLOAD_BYTES-1:0] data_q;
  logic [NUM_CHANNELS-1:0]      out_vld_q;
  logic                         rsp_vld_q;
  logic [7:0]                   rsp_dat_q;
  logic [TMO_W-1:0]             tmo_q;
  logic [PULSE_W-1:0]           pulse_q;
  logic [15:0]                  err_q;

  logic             cmd_acc;
  logic [8:0]       op_off;
  logic             op_hit;
  logic [CH_W-1:0]  op_ch;
  logic [LEN_W-1:0] op_len;
  logic [LEN_W-1:0] ch_len;
  logic [LEN_W-1:0] wr_idx;
  logic             tmo_hit;
  logic [15:0]      err_d;

  // Ready depends on registered state only, so no input reaches it combinationally.
  assign cmd_s_ready = (state_q == S_IDLE) || (state_q == S_PAYLOAD) || (state_q == S_RESET_CONFIRM);
  assign cmd_acc     = cmd_s_valid && cmd_s_ready;

  assign op_off  = {1'b0, cmd_s_data} - {1'b0, OPCODE_BASE};
  assign op_hit  = (cmd_s_data >= OPCODE_BASE) && (op_off < 9'(NUM_CHANNELS));
  assign op_ch   = CH_W'(op_off);
  assign op_len  = LEN_W'(CH_PAYLOAD_BYTES[op_ch]);
  assign ch_len  = LEN_W'(CH_PAYLOAD_BYTES[ch_q]);
  assign wr_idx  = ch_len - bytes_left_q;
  // An accepted byte in the limit cycle wins over the timeout.
  assign tmo_hit = !cmd_acc && (tmo_q == TMO_LAST);
  assign err_d   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      bytes_left_q <= '0;
      len_q        <= '0;
      data_q       <= '0;
      out_vld_q    <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_dat_q    <= 8'h00;
      tmo_q        <= '0;
      pulse_q      <= '0;
      err_q        <= 16'h0000;
    end else begin
      if (pulse_q != '0) pulse_q <= pulse_q - 1'b1;
      case (state_q)
        S_IDLE: begin
          if (cmd_acc) begin
            tmo_q <= '0;
            if (cmd_s_data == RST_OP) begin
              state_q <= S_RESET_CONFIRM;
            end else if (op_hit) begin
              ch_q         <= op_ch;
              bytes_left_q <= op_len;
              len_q        <= op_len;
              data_q       <= '0;
              state_q      <= S_PAYLOAD;
            end else begin
              rsp_dat_q <= NAK;
              rsp_vld_q <= 1'b1;
              err_q     <= err_d;
              state_q   <= S_RESP;
            end
          end
        end
        S_PAYLOAD: begin
          if (cmd_acc) begin
            data_q[{wr_idx, 3'b000} +: 8] <= cmd_s_data;
            bytes_left_q <= bytes_left_q - 1'b1;
            tmo_q        <= '0;
            if (bytes_left_q == LEN_W'(1)) begin
              out_vld_q <= NUM_CHANNELS'(1) << ch_q;
              state_q   <= S_DELIVER;
            end
          end else if (tmo_hit) begin
            data_q    <= '0;
            len_q     <= '0;
            tmo_q     <= '0;
            rsp_dat_q <= TMO;
            rsp_vld_q <= 1'b1;
            err_q     <= err_d;
            state_q   <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_DELIVER: begin
          if (out_m_ready[ch_q]) begin
            out_vld_q <= '0;
            rsp_dat_q <= ACK;
            rsp_vld_q <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_RESET_CONFIRM: begin
          if (cmd_acc) begin
            tmo_q     <= '0;
            rsp_vld_q <= 1'b1;
            state_q   <= S_RESP;
            if (cmd_s_data == RST_OP) begin
              pulse_q   <= PULSE_LEN;
              rsp_dat_q <= ACK;
            end else begin
              rsp_dat_q <= NAK;
              err_q     <= err_d;
            end
          end else if (tmo_hit) begin
            tmo_q     <= '0;
            rsp_dat_q <= TMO;
            rsp_vld_q <= 1'b1;
            err_q     <= err_d;
            state_q   <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_m_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_m_valid = rsp_vld_q;
  assign rsp_m_data  = rsp_dat_q;
  assign out_m_valid = out_vld_q;
  assign out_m_data  = data_q;
  assign out_m_len   = len_q;
  assign cmd_reset   = (pulse_q != '0);
  assign err_count   = err_q;

endmodule

// File: tb/tb_cmd_frame_router.sv
// Directed bench for cmd_frame_router with TIMEOUT_CYCLES=16 and RESET_PULSE=8; outputs sampled 1ns after the rising edge.
module tb_cmd_frame_router;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cmd_s_valid = 1'b0;
  logic         cmd_s_ready;
  logic [7:0]   cmd_s_data = 8'h00;
  logic         rsp_m_valid;
  logic         rsp_m_ready = 1'b0;
  logic [7:0]   rsp_m_data;
  logic [3:0]   out_m_valid;
  logic [3:0]   out_m_ready = 4'b0000;
  logic [511:0] out_m_data;
  logic [6:0]   out_m_len;
  logic         cmd_reset;
  logic [15:0]  err_count;

  int vecs = 0;
  int errs = 0;

  cmd_frame_router #(
    .NUM_CHANNELS      (4),
    .OPCODE_BASE       (8'hA0),
    .MAX_PAYLOAD_BYTES (64),
    .TIMEOUT_CYCLES    (16),
    .RESET_PULSE       (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_s_valid (cmd_s_valid),
    .cmd_s_ready (cmd_s_ready),
    .cmd_s_data  (cmd_s_data),
    .rsp_m_valid (rsp_m_valid),
    .rsp_m_ready (rsp_m_ready),
    .rsp_m_data  (rsp_m_data),
    .out_m_valid (out_m_valid),
    .out_m_ready (out_m_ready),
    .out_m_data  (out_m_data),
    .out_m_len   (out_m_len),
    .cmd_reset   (cmd_reset),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    chk("cmd_s_ready before byte", cmd_s_ready, 1'b1);
    cmd_s_valid = 1'b1;
    cmd_s_data  = b;
    tick();
    cmd_s_valid = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " cmd_s_ready"}, cmd_s_ready, 1'b1);
    chk({tag, " rsp_m_valid"}, rsp_m_valid, 1'b0);
    chk({tag, " rsp_m_data"},  rsp_m_data,  8'h00);
    chk({tag, " out_m_valid"}, out_m_valid, 4'b0000);
    chk({tag, " out_m_data"},  out_m_data,  512'h0);
    chk({tag, " out_m_len"},   out_m_len,   7'd0);
    chk({tag, " cmd_reset"},   cmd_reset,   1'b0);
    chk({tag, " err_count"},   err_count,   16'd0);
  endtask

  initial begin
    int hi;

    // Reset state
    repeat (3) tick();
    chk_reset_values("reset");
    rstn = 1'b1;
    tick();

    // Basic frame on channel 1 with the sink ready
    out_m_ready = 4'b0010;
    send(8'hA1);
    send(8'h11);
    send(8'h22);
    chk("frame valid",   out_m_valid, 4'b0010);
    chk("frame data",    out_m_data,  512'h2211);
    chk("frame len",     out_m_len,   7'd2);
    chk("frame busy",    cmd_s_ready, 1'b0);
    tick();
    chk("frame rsp vld", rsp_m_valid, 1'b1);
    chk("frame rsp dat", rsp_m_data,  8'h06);
    chk("frame vld off", out_m_valid, 4'b0000);
    rsp_m_ready = 1'b1;
    tick();
    chk("frame rsp done", rsp_m_valid, 1'b0);
    chk("frame err",      err_count,   16'd0);

    // Sink backpressure; readies of other channels must be ignored
    out_m_ready = 4'b1101;
    rsp_m_ready = 1'b0;
    send(8'hA1);
    send(8'h33);
    send(8'h44);
    for (int i = 0; i < 10; i++) begin
      chk("bp valid", out_m_valid, 4'b0010);
      chk("bp data",  out_m_data,  512'h4433);
      chk("bp busy",  cmd_s_ready, 1'b0);
      chk("bp no rsp", rsp_m_valid, 1'b0);
      tick();
    end
    out_m_ready = 4'b0010;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rsp hold vld", rsp_m_valid, 1'b1);
      chk("rsp hold dat", rsp_m_data,  8'h06);
      chk("rsp hold busy", cmd_s_ready, 1'b0);
      tick();
    end
    rsp_m_ready = 1'b1;
    tick();
    chk("bp rsp done", rsp_m_valid, 1'b0);

    // Unknown opcode
    send(8'h7E);
    chk("nak vld",   rsp_m_valid, 1'b1);
    chk("nak dat",   rsp_m_data,  8'h15);
    chk("nak err",   err_count,   16'd1);
    chk("nak noout", out_m_valid, 4'b0000);
    tick();

    // Timeout after 16 idle cycles
    out_m_ready = 4'b0001;
    send(8'hA0);
    send(8'h11);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo not yet", rsp_m_valid, 1'b0);
    tick();
    chk("tmo vld",   rsp_m_valid, 1'b1);
    chk("tmo dat",   rsp_m_data,  8'h18);
    chk("tmo err",   err_count,   16'd2);
    chk("tmo noout", out_m_valid, 4'b0000);
    tick();

    // Byte landing in the limit cycle wins
    send(8'hA0);
    send(8'h11);
    for (int i = 0; i < 15; i++) tick();
    send(8'h22);
    chk("late byte valid", out_m_valid, 4'b0001);
    chk("late byte data",  out_m_data,  512'h2211);
    chk("late byte norsp", rsp_m_valid, 1'b0);
    tick();
    chk("late byte ack", rsp_m_data, 8'h06);
    chk("late byte err", err_count,  16'd2);
    tick();

    // Confirmed soft reset
    send(8'h55);
    chk("rst pending", cmd_reset, 1'b0);
    send(8'h55);
    chk("rst ack vld", rsp_m_valid, 1'b1);
    chk("rst ack dat", rsp_m_data,  8'h06);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_reset) hi++;
      tick();
    end
    chk("rst pulse width", 32'(hi), 32'd8);

    // Aborted soft reset: A0 is consumed, not treated as an opcode
    send(8'h55);
    send(8'hA0);
    chk("rst abort vld", rsp_m_valid, 1'b1);
    chk("rst abort dat", rsp_m_data,  8'h15);
    chk("rst abort err", err_count,   16'd3);
    chk("rst abort pls", cmd_reset,   1'b0);
    tick();
    chk("rst abort idle", cmd_s_ready, 1'b1);
    chk("rst abort noout", out_m_valid, 4'b0000);
    chk("rst abort nopls", cmd_reset, 1'b0);

    // Async reset mid-payload, then a clean frame
    out_m_ready = 4'b0100;
    send(8'hA2);
    send(8'h33);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_values("async");
    tick();
    rstn = 1'b1;
    tick();
    send(8'hA2);
    send(8'h44);
    send(8'h55);
    chk("post rst valid", out_m_valid, 4'b0100);
    chk("post rst data",  out_m_data,  512'h5544);
    chk("post rst len",   out_m_len,   7'd2);
    tick();
    chk("post rst ack",   rsp_m_data,  8'h06);
    chk("post rst err",   err_count,   16'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
